// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around a single half adder.
// Each bit takes two half-adder passes (HA1: a^b, HA2: partial^carry), so an
// addition of WIDTH bits completes 2*WIDTH edges after the accepting edge.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - begin an addition (honoured only in IDLE)
//   a, b  - operands, sampled on the accepting edge
//   cin   - carry-in, sampled on the accepting edge
//   sum   - registered result
//   cout  - registered carry-out of bit WIDTH-1
//   busy  - high while in HA1, HA2 or DONE
//   done  - one-cycle completion pulse

module half_adder (
  input  logic a,
  input  logic b,
  output logic c,
  output logic carry
);
  assign c     = a ^ b;
  assign carry = a & b;
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, HA1, HA2, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    idx;
  logic             s1, c1, carry_reg;
  logic             ha_x, ha_y, ha_s, ha_co;
  logic             last_bit;

  assign last_bit = (idx == IW'(WIDTH - 1));

  // The only adder in the design; its inputs are steered by the FSM phase.
  half_adder u_ha (
    .a     (ha_x),
    .b     (ha_y),
    .c     (ha_s),
    .carry (ha_co)
  );

  // Operand mux: bit pair in HA1, partial sum with running carry otherwise.
  always_comb begin
    ha_x = s1;
    ha_y = carry_reg;
    if (state == HA1) begin
      ha_x = a_reg[idx];
      ha_y = b_reg[idx];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = HA1;
      HA1:  state_next = HA2;
      HA2:  state_next = last_bit ? DONE : HA1;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      idx       <= '0;
      s1        <= 1'b0;
      c1        <= 1'b0;
      carry_reg <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
          end
        end
        HA1: begin
          s1 <= ha_s;
          c1 <= ha_co;
        end
        HA2: begin
          sum[idx]  <= ha_s;
          carry_reg <= c1 | ha_co;
          // Index saturates at the top bit; cout is published only then.
          if (last_bit) cout <= c1 | ha_co;
          else          idx  <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
